// File: rtl/ram_port_arb_if.sv
// Bus bundle for the two-requester single-port RAM arbiter.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface ram_port_arb_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_port_arb.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Grants are combinational; the accepted access is registered onto the RAM
// port one cycle later, and a read tag follows it so the read data returns
// to the right requester two cycles after acceptance.
module ram_port_arb #(
  parameter int AW        = 6,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_port_arb_if.slave  bus
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} owner_t;

  owner_t        owner;
  logic [3:0]    burst_cnt;

  logic          gnt0_p0;
  logic          gnt1_p0;
  logic          acc_p0;
  logic          sel_p0;
  logic          we_p0;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] wdata_p0;

  logic          ram_en_p1;
  logic          ram_we_p1;
  logic [AW-1:0] ram_addr_p1;
  logic [DW-1:0] ram_wdata_p1;
  logic          rd_vld_p1;
  logic          rd_id_p1;

  logic          rd_vld_p2;
  logic          rd_id_p2;

  // Burst counter increment that sticks at the 4-bit ceiling.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // ---- stage p0: arbitration and request mux (combinational) ----

  // Lone requester wins; under contention the owner keeps the port until its
  // burst allowance is spent, then the other side takes over.
  always_comb begin
    gnt0_p0 = 1'b0;
    gnt1_p0 = 1'b0;
    if (rst_n) begin
      if (bus.req0 && bus.req1) begin
        if (burst_cnt < BURST_LIM) begin
          gnt0_p0 = (owner == OWN0);
          gnt1_p0 = (owner == OWN1);
        end else begin
          gnt0_p0 = (owner == OWN1);
          gnt1_p0 = (owner == OWN0);
        end
      end else begin
        gnt0_p0 = bus.req0;
        gnt1_p0 = bus.req1;
      end
    end
  end

  assign acc_p0   = gnt0_p0 | gnt1_p0;
  assign sel_p0   = gnt1_p0;
  assign we_p0    = sel_p0 ? bus.we1    : bus.we0;
  assign addr_p0  = sel_p0 ? bus.addr1  : bus.addr0;
  assign wdata_p0 = sel_p0 ? bus.wdata1 : bus.wdata0;

  assign bus.gnt0 = gnt0_p0;
  assign bus.gnt1 = gnt1_p0;

  // Owner/burst state: idle cycles wipe the burst history, owner changes
  // restart it at one, repeat grants to the owner count up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN0;
      burst_cnt <= 4'd0;
    end else if (!acc_p0) begin
      burst_cnt <= 4'd0;
    end else if (sel_p0 == logic'(owner)) begin
      burst_cnt <= sat_inc(burst_cnt);
    end else begin
      owner     <= sel_p0 ? OWN1 : OWN0;
      burst_cnt <= 4'd1;
    end
  end

  // ---- stage p1: registered RAM port and read tag ----

  // RAM command register; address and write data hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_p1    <= 1'b0;
      ram_we_p1    <= 1'b0;
      ram_addr_p1  <= '0;
      ram_wdata_p1 <= '0;
    end else begin
      ram_en_p1 <= acc_p0;
      ram_we_p1 <= acc_p0 & we_p0;
      if (acc_p0) begin
        ram_addr_p1  <= addr_p0;
        ram_wdata_p1 <= wdata_p0;
      end
    end
  end

  // Read tag travels two cycles to line up with the RAM's registered output;
  // reset drops any tag in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1 <= 1'b0;
      rd_id_p1  <= 1'b0;
      rd_vld_p2 <= 1'b0;
      rd_id_p2  <= 1'b0;
    end else begin
      rd_vld_p1 <= acc_p0 & ~we_p0;
      rd_id_p1  <= sel_p0;
      rd_vld_p2 <= rd_vld_p1;
      rd_id_p2  <= rd_id_p1;
    end
  end

  assign bus.ram_en    = ram_en_p1;
  assign bus.ram_we    = ram_we_p1;
  assign bus.ram_addr  = ram_addr_p1;
  assign bus.ram_wdata = ram_wdata_p1;

  // ---- stage p2: read return ----

  assign bus.rvalid0 = rd_vld_p2 & ~rd_id_p2;
  assign bus.rvalid1 = rd_vld_p2 &  rd_id_p2;
  assign bus.rdata   = bus.ram_rdata;

endmodule

// File: tb/tb_ram_port_arb.sv
// Bench for ram_port_arb: behavioural RAM, shadow memory and a scoreboard of
// expected RAM commands and read returns, plus per-scenario directed tasks.
module tb_ram_port_arb;
  localparam int AW        = 6;
  localparam int DW        = 8;
  localparam int BURST_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arb_if #(.AW(AW), .DW(DW)) bus();

  ram_port_arb #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ram_item_t;

  typedef struct {
    int            cyc;
    logic          id;
    logic [DW-1:0] data;
  } rd_item_t;

  ram_item_t     ram_q[$];
  rd_item_t      rd_q[$];
  logic [DW-1:0] mem  [2**AW];
  logic [DW-1:0] smem [2**AW];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  int            cyc;
  int            checks;
  int            errors;

  // Behavioural single-port RAM, read data registered one cycle after ram_en.
  always @(posedge clk) begin
    if (bus.ram_en === 1'b1) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0  = 1'b0; bus.we1  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive_idle();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    ram_q.delete();
    rd_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard: checks RAM-side outputs and read returns each cycle, then
  // records what this cycle's accepted access should produce later.
  task automatic monitor_loop();
    ram_item_t ri;
    rd_item_t  di;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        last_addr  = '0;
        last_wdata = '0;
      end else begin
        cyc++;
        checks++;
        if ((bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1) ||
            (bus.gnt0 === 1'b1 && bus.req0 !== 1'b1) ||
            (bus.gnt1 === 1'b1 && bus.req1 !== 1'b1)) begin
          errors++;
          $display("FAIL gnt_legal cyc=%0d got gnt0=%b gnt1=%b req0=%b req1=%b, required one-hot grant to a requester",
                   cyc, bus.gnt0, bus.gnt1, bus.req0, bus.req1);
        end
        checks++;
        if (bus.ram_en === 1'b1) begin
          if (ram_q.size() == 0 || ram_q[0].cyc != cyc) begin
            errors++;
            $display("FAIL ram_en_unexpected cyc=%0d got ram_en=1, required 0", cyc);
          end else begin
            ri = ram_q.pop_front();
            checks++;
            if (bus.ram_we !== ri.we || bus.ram_addr !== ri.addr ||
                (ri.we && bus.ram_wdata !== ri.wdata)) begin
              errors++;
              $display("FAIL ram_cmd cyc=%0d got we=%b addr=%0d wdata=%0d, required we=%b addr=%0d wdata=%0d",
                       cyc, bus.ram_we, bus.ram_addr, bus.ram_wdata, ri.we, ri.addr, ri.wdata);
            end
            last_addr  = ri.addr;
            last_wdata = ri.wdata;
          end
        end else begin
          if (ram_q.size() != 0 && ram_q[0].cyc == cyc) begin
            ri = ram_q.pop_front();
            errors++;
            $display("FAIL ram_en_missing cyc=%0d got ram_en=%b, required 1 addr=%0d", cyc, bus.ram_en, ri.addr);
          end
          checks++;
          if (bus.ram_we !== 1'b0 || bus.ram_addr !== last_addr || bus.ram_wdata !== last_wdata) begin
            errors++;
            $display("FAIL ram_hold cyc=%0d got we=%b addr=%0d wdata=%0d, required we=0 addr=%0d wdata=%0d",
                     cyc, bus.ram_we, bus.ram_addr, bus.ram_wdata, last_addr, last_wdata);
          end
        end
        checks++;
        if (bus.rvalid0 === 1'b1 || bus.rvalid1 === 1'b1) begin
          if (bus.rvalid0 === 1'b1 && bus.rvalid1 === 1'b1) begin
            errors++;
            $display("FAIL rvalid_both cyc=%0d got rvalid0=1 rvalid1=1, required at most one", cyc);
          end else if (rd_q.size() == 0 || rd_q[0].cyc != cyc) begin
            errors++;
            $display("FAIL rvalid_unexpected cyc=%0d got rvalid0=%b rvalid1=%b, required none", cyc, bus.rvalid0, bus.rvalid1);
          end else begin
            di = rd_q.pop_front();
            checks++;
            if (bus.rvalid1 !== di.id || bus.rdata !== di.data) begin
              errors++;
              $display("FAIL read_return cyc=%0d got id=%b rdata=%0d, required id=%b rdata=%0d",
                       cyc, bus.rvalid1, bus.rdata, di.id, di.data);
            end
          end
        end else if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
          di = rd_q.pop_front();
          errors++;
          $display("FAIL rvalid_missing cyc=%0d got rvalid0=%b rvalid1=%b, required rvalid%0d=1",
                   cyc, bus.rvalid0, bus.rvalid1, di.id);
        end
        if (bus.req0 === 1'b1 && bus.gnt0 === 1'b1) begin
          ram_q.push_back('{cyc + 1, bus.we0, bus.addr0, bus.wdata0});
          if (bus.we0) smem[bus.addr0] = bus.wdata0;
          else         rd_q.push_back('{cyc + 2, 1'b0, smem[bus.addr0]});
        end
        if (bus.req1 === 1'b1 && bus.gnt1 === 1'b1) begin
          ram_q.push_back('{cyc + 1, bus.we1, bus.addr1, bus.wdata1});
          if (bus.we1) smem[bus.addr1] = bus.wdata1;
          else         rd_q.push_back('{cyc + 2, 1'b1, smem[bus.addr1]});
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    #3;
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt got gnt0=%b gnt1=%b, required 0 0", bus.gnt0, bus.gnt1);
    end
    checks++;
    if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_en got ram_en=%b ram_we=%b, required 0 0", bus.ram_en, bus.ram_we);
    end
    checks++;
    if (bus.ram_addr !== '0 || bus.ram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%0d wdata=%0d, required 0 0", bus.ram_addr, bus.ram_wdata);
    end
    checks++;
    if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_rvalid got %b %b, required 0 0", bus.rvalid0, bus.rvalid1);
    end
    checks++;
    if (dut.burst_cnt !== 4'd0 || logic'(dut.owner) !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got burst_cnt=%0d owner=%b, required 0 0", dut.burst_cnt, dut.owner);
    end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd5; bus.wdata0 = 8'd0;
    bus.req1 = 1'b0;
    #3;
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt got gnt0=%b gnt1=%b, required 1 0", bus.gnt0, bus.gnt1);
    end
    @(negedge clk);
    bus.req0 = 1'b0;
    #3;
    checks++;
    if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 6'd5 || bus.rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL single_cmd got en=%b we=%b addr=%0d rvalid0=%b, required 1 0 5 0",
               bus.ram_en, bus.ram_we, bus.ram_addr, bus.rvalid0);
    end
    @(negedge clk);
    #3;
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0 || bus.rdata !== smem[5]) begin
      errors++;
      $display("FAIL single_return got rvalid0=%b rvalid1=%b rdata=%0d, required 1 0 %0d",
               bus.rvalid0, bus.rvalid1, bus.rdata, smem[5]);
    end
    @(negedge clk);
    #3;
    checks++;
    if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse got rvalid0=%b rvalid1=%b, required 0 0", bus.rvalid0, bus.rvalid1);
    end
    idle_cycles(3);
  endtask

  task automatic test_contention();
    logic exp1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'(i);
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'(32 + i);
      exp1 = ((i / BURST_MAX) % 2) == 1;
      #3;
      checks++;
      if (bus.gnt1 !== exp1 || bus.gnt0 !== !exp1) begin
        errors++;
        $display("FAIL contention i=%0d got gnt0=%b gnt1=%b, required gnt1=%b", i, bus.gnt0, bus.gnt1, exp1);
      end
    end
    idle_cycles(3);
  endtask

  task automatic test_owner_release();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      bus.req0 = (i < 2); bus.we0 = 1'b0; bus.addr0 = 6'(40 + i);
      bus.req1 = 1'b1;    bus.we1 = 1'b0; bus.addr1 = 6'(50 + i);
      #3;
      checks++;
      if (bus.gnt0 !== (i < 2) || bus.gnt1 !== (i >= 2)) begin
        errors++;
        $display("FAIL release_gnt i=%0d got gnt0=%b gnt1=%b, required gnt0=%b", i, bus.gnt0, bus.gnt1, (i < 2));
      end
    end
    // Owner stays requester 1; its counter restarts at 1 and saturates at 15.
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      bus.addr1 = 6'(k);
      #3;
      checks++;
      if (bus.gnt1 !== 1'b1 || (k == 0 && dut.burst_cnt !== 4'd1)) begin
        errors++;
        $display("FAIL release_hold k=%0d got gnt1=%b burst_cnt=%0d, required gnt1=1 (burst_cnt=1 at k=0)",
                 k, bus.gnt1, dut.burst_cnt);
      end
    end
    @(negedge clk);
    drive_idle();
    #3;
    checks++;
    if (dut.burst_cnt !== 4'd15) begin
      errors++;
      $display("FAIL burst_saturate got burst_cnt=%0d, required 15", dut.burst_cnt);
    end
    idle_cycles(3);
  endtask

  task automatic test_write_stream();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bus.req0 = 1'b0;
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'(i); bus.wdata1 = 8'(i * 5 + 17);
      #3;
      checks++;
      if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0 ||
          (i > 0 && (bus.ram_we !== 1'b1 || bus.ram_addr !== 6'(i - 1) || bus.ram_wdata !== 8'((i - 1) * 5 + 17)))) begin
        errors++;
        $display("FAIL write_stream i=%0d got gnt1=%b we=%b addr=%0d wdata=%0d", i, bus.gnt1, bus.ram_we, bus.ram_addr, bus.ram_wdata);
      end
    end
    idle_cycles(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'(i * 21);
    end
    idle_cycles(3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.req0 = (i % 2 == 0); bus.we0 = (i % 3 == 0);
      bus.addr0 = 6'($urandom_range(0, 63)); bus.wdata0 = 8'($urandom_range(0, 255));
      bus.req1 = (i % 2 == 1); bus.we1 = (i % 5 == 0);
      bus.addr1 = 6'($urandom_range(0, 63)); bus.wdata1 = 8'($urandom_range(0, 255));
      #3;
      checks++;
      if (bus.gnt0 !== bus.req0 || bus.gnt1 !== bus.req1) begin
        errors++;
        $display("FAIL b2b_gnt i=%0d got gnt0=%b gnt1=%b, required %b %b", i, bus.gnt0, bus.gnt1, bus.req0, bus.req1);
      end
    end
    idle_cycles(3);
  endtask

  task automatic test_idle_history();
    logic exp1;
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd33;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_idle();
      #3;
      checks++;
      if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 ||
          (k >= 1 && (bus.ram_en !== 1'b0 || bus.ram_addr !== 6'd33 || dut.burst_cnt !== 4'd0))) begin
        errors++;
        $display("FAIL idle k=%0d got gnt=%b%b ram_en=%b addr=%0d burst_cnt=%0d, required 00 0 33 0",
                 k, bus.gnt0, bus.gnt1, bus.ram_en, bus.ram_addr, dut.burst_cnt);
      end
    end
    // After the idle gap requester 0 gets a fresh full burst.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'(i);
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'(60 - i);
      exp1 = (i >= BURST_MAX);
      #3;
      checks++;
      if (bus.gnt1 !== exp1 || bus.gnt0 !== !exp1) begin
        errors++;
        $display("FAIL history i=%0d got gnt0=%b gnt1=%b, required gnt1=%b", i, bus.gnt0, bus.gnt1, exp1);
      end
    end
    idle_cycles(3);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd9;
    #3;
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_gnt got gnt0=%b, required 1", bus.gnt0);
    end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    ram_q.delete();
    rd_q.delete();
    #3;
    checks++;
    if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== '0 || bus.ram_wdata !== '0 ||
        bus.rvalid0 !== 1'b0 || bus.gnt0 !== 1'b0 || dut.burst_cnt !== 4'd0) begin
      errors++;
      $display("FAIL midrst_outputs got en=%b we=%b addr=%0d wdata=%0d rvalid0=%b gnt0=%b cnt=%0d, required all 0",
               bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rvalid0, bus.gnt0, dut.burst_cnt);
    end
    @(negedge clk);
    #3;
    checks++;
    if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_reset got rvalid0=%b rvalid1=%b, required 0 0", bus.rvalid0, bus.rvalid1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #3;
      checks++;
      if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin
        errors++;
        $display("FAIL midrst_after k=%0d got rvalid0=%b rvalid1=%b, required 0 0", k, bus.rvalid0, bus.rvalid1);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    last_addr  = '0;
    last_wdata = '0;
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]  = 8'(i * 7 + 3);
      smem[i] = 8'(i * 7 + 3);
    end
    drive_idle();
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_single_read();
    test_contention();
    test_owner_release();
    test_write_stream();
    test_back_to_back();
    test_idle_history();
    test_reset_mid_read();
    idle_cycles(3);
    @(negedge clk);
    #4;
    checks++;
    if (ram_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain got ram_q=%0d rd_q=%0d pending, required 0 0", ram_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_port_arb.md
RAM_PORT_ARB -- requirements
Module: ram_port_arb

Interface
REQ-001 The module SHALL have parameter AW, default 6, meaning RAM address width (64 words).
REQ-002 The module SHALL have parameter DW, default 8, meaning RAM data width.
REQ-003 The module SHALL have parameter BURST_MAX, default 4, meaning maximum consecutive grants to one requester while the other is requesting (legal range 1..15).
REQ-004 Ports, in order (clock and reset first):
- clk  input  1  the single clock; all logic on its rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- req0, req1  input  1 each  access request from requester 0 / 1.
- we0, we1  input  1 each  1 = write, 0 = read; qualified by req.
- addr0, addr1  input  AW each  access address.
- wdata0, wdata1  input  DW each  write data.
- gnt0, gnt1  output  1 each  combinational grant; the access is accepted in any cycle where req and gnt are both high.
- rvalid0, rvalid1  output  1 each  read data valid for requester 0 / 1.
- rdata  output  DW  read data shared by both requesters, qualified by rvalid0/rvalid1.
- ram_en  output  1  registered RAM port enable.
- ram_we  output  1  registered RAM write enable.
- ram_addr  output  AW  registered RAM address.
- ram_wdata  output  DW  registered RAM write data.
- ram_rdata  input  DW  RAM read data, valid one cycle after ram_en with ram_we=0.

Function
REQ-005 At most one of gnt0/gnt1 SHALL be high in any cycle; gntN SHALL never be high while reqN is low.
REQ-006 Owner register SHALL hold the last-granted requester; after reset the owner is requester 0.
REQ-007 If exactly one requester requests, it SHALL be granted, becoming owner.
REQ-008 If both request, the owner SHALL be granted while burst_cnt < BURST_MAX; otherwise the other requester SHALL be granted and become owner.
REQ-009 burst_cnt SHALL be 0 after reset, increment (saturating at 15) on each grant to the current owner, reload to 1 on each grant that changes owner, and clear to 0 in any cycle with no grant.
REQ-010 An owner that drops req for one cycle SHALL lose its burst history (counter cleared per REQ-009).
REQ-011 Accepted access in cycle T SHALL appear on ram_en=1, ram_we, ram_addr and ram_wdata in cycle T+1; in cycles with no accepted access, ram_en and ram_we SHALL be 0 and ram_addr and ram_wdata SHALL hold their values.
REQ-012 An accepted read in cycle T SHALL assert rvalidN of the granted requester for exactly one cycle at T+2. rdata SHALL equal ram_rdata. Accepted writes SHALL produce no rvalid.
REQ-013 The module SHALL support back-to-back accepted accesses every cycle (throughput 1 per cycle), with the read-tag pipeline 2 deep and no stalls.
REQ-014 rvalid0 and rvalid1 SHALL never be high in the same cycle.

Reset
REQ-015 While rst_n is low, the module SHALL hold ram_en, ram_we, rvalid0, rvalid1, burst_cnt at 0, ram_addr and ram_wdata at 0, and the owner at requester 0. gnt0/gnt1 SHALL be forced to 0.
REQ-016 Reset asserted mid-operation SHALL discard in-flight read tags; no rvalid SHALL appear after rst_n deasserts for reads accepted before reset.

Verification
REQ-017 Single read: req0=1, we0=0, addr0=5 for one cycle T -> gnt0=1 at T; ram_en=1, ram_we=0, ram_addr=5 at T+1; rvalid0=1 with rdata=ram_rdata at T+2; rvalid1=0 throughout.
REQ-018 Contention: req0 and req1 both held high from reset release, BURST_MAX=4 -> grants follow 0,0,0,0,1,1,1,1,0,...
REQ-019 Owner release: req0 held for 2 cycles, req1 held throughout -> gnt0 for 2 cycles, then gnt1 continuously; burst_cnt=1 on the first gnt1 cycle.
REQ-020 Write stream: req1=1, we1=1, addr1 0..63 on consecutive cycles -> ram_we=1 with matching ram_addr and ram_wdata one cycle later each cycle; no rvalid.
REQ-021 Reset mid-read: read accepted at T, rst_n low at T+1 -> rvalid0 stays 0 and all outputs are at reset values.
REQ-022 Idle: no requests for 3 cycles -> ram_en=0, gnt0=gnt1=0, burst_cnt=0, ram_addr held.
